// File: rtl/wb_regfile.sv
// Write-back architectural state: 32x32 GPR file, HI/LO pair and flags register,
// with same-cycle write-to-read bypass on every read-out path.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_flags,
  input  logic              wb_flags_we,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] flags_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] flags_q;

  logic gpr_write;

  // r0 is hardwired to zero, so a write aimed at it is simply dropped.
  assign gpr_write = wb_wreg && (wb_wd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (gpr_write) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      if (wb_we) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
      if (wb_flags_we) begin
        flags_q <= wb_flags;
      end
    end
  end

  // The enable is tested before the address is used, so an undriven address on a
  // disabled port never reaches the output.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              ren,
    input logic [ADDR_W-1:0] raddr
  );
    logic [DATA_W-1:0] value;
    value = '0;
    if (rst) begin
      value = '0;
    end else if (!ren) begin
      value = '0;
    end else if (raddr == '0) begin
      value = '0;
    end else if (wb_wreg && (raddr == wb_wd)) begin
      value = wb_wdata;
    end else begin
      value = regs[raddr];
    end
    return value;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    flags_o = '0;
    if (!rst) begin
      hi_o    = wb_we       ? wb_hi    : hi_q;
      lo_o    = wb_we       ? wb_lo    : lo_q;
      flags_o = wb_flags_we ? wb_flags : flags_q;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed scenarios plus randomized traffic checked
// against an array-based architectural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_we;
  logic [31:0] wb_flags;
  logic        wb_flags_we;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] flags_o;

  logic [31:0] model [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .wb_wd(wb_wd),
    .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata),
    .wb_hi(wb_hi),
    .wb_lo(wb_lo),
    .wb_we(wb_we),
    .wb_flags(wb_flags),
    .wb_flags_we(wb_flags_we),
    .re1(re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2(re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .hi_o(hi_o),
    .lo_o(lo_o),
    .flags_o(flags_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r, input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
    input logic we, input logic [31:0] hi, input logic [31:0] lo,
    input logic fwe, input logic [31:0] flags,
    input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2
  );
    rst = r; wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
    wb_we = we; wb_hi = hi; wb_lo = lo;
    wb_flags_we = fwe; wb_flags = flags;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  // Architectural view of a read: what decode should see this cycle.
  function automatic logic [31:0] expRead(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0;
    if (wb_wreg && a == wb_wd) return wb_wdata;
    return model[a];
  endfunction

  // Checks all outputs against the model mid-cycle, then commits the cycle.
  task automatic stepCycle(input string tag);
    #4;
    checkOutput({tag, ".rdata1"}, rdata1, expRead(re1, raddr1));
    checkOutput({tag, ".rdata2"}, rdata2, expRead(re2, raddr2));
    checkOutput({tag, ".hi"}, hi_o, rst ? 32'h0 : (wb_we ? wb_hi : m_hi));
    checkOutput({tag, ".lo"}, lo_o, rst ? 32'h0 : (wb_we ? wb_lo : m_lo));
    checkOutput({tag, ".flags"}, flags_o, rst ? 32'h0 : (wb_flags_we ? wb_flags : m_flags));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_flags = 32'h0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) model[wb_wd] = wb_wdata;
      if (wb_we) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
      if (wb_flags_we) m_flags = wb_flags;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_flags = 32'h0;
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 1, 32'h11, 32'h22, 1, 32'h33, 1, 5, 1, 5);
    @(posedge clk); #1;

    // Reset held two cycles while a write is presented
    for (int c = 0; c < 2; c++) begin
      #2;
      checkOutput("rst.rdata1", rdata1, 32'h0);
      checkOutput("rst.hi", hi_o, 32'h0);
      stepCycle("rst");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    #2;
    checkOutput("post_rst.r5", rdata1, 32'h0);
    checkOutput("post_rst.flags", flags_o, 32'h0);
    stepCycle("post_rst");

    // Write r7 with same-cycle bypass, then read it back from storage
    applyStimulus(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    #2;
    checkOutput("bypass.r7", rdata2, 32'h12345678);
    stepCycle("wr_r7");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    #2;
    checkOutput("stored.r7", rdata1, 32'h12345678);
    stepCycle("rd_r7");

    // r0 write must be ignored
    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0, 1, 7);
    #2;
    checkOutput("r0.same", rdata1, 32'h0);
    stepCycle("r0_wr");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7);
    #2;
    checkOutput("r0.next", rdata1, 32'h0);
    checkOutput("r0.r7_kept", rdata2, 32'h12345678);
    stepCycle("r0_rd");

    // Read enables
    applyStimulus(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("wr_r3");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3);
    #2;
    checkOutput("ren.off", rdata1, 32'h0);
    checkOutput("ren.on", rdata2, 32'hA5A5A5A5);
    stepCycle("ren");

    // HI/LO and flags enables
    applyStimulus(0, 0, 0, 0, 1, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("hilo.hi_same", hi_o, 32'h1);
    checkOutput("hilo.lo_same", lo_o, 32'h2);
    stepCycle("hilo_wr");
    applyStimulus(0, 0, 0, 0, 0, 32'h9, 32'h9, 0, 32'hF, 0, 0, 0, 0);
    #2;
    checkOutput("hilo.hi_kept", hi_o, 32'h1);
    checkOutput("hilo.lo_kept", lo_o, 32'h2);
    checkOutput("flags.kept", flags_o, 32'h0);
    stepCycle("hilo_hold");

    // All three write paths in one cycle
    applyStimulus(0, 1, 31, 32'h55, 1, 32'h66, 32'h77, 1, 32'h8, 1, 31, 1, 31);
    for (int c = 0; c < 2; c++) begin
      #2;
      checkOutput("simul.rdata1", rdata1, 32'h55);
      checkOutput("simul.rdata2", rdata2, 32'h55);
      checkOutput("simul.hi", hi_o, 32'h66);
      checkOutput("simul.lo", lo_o, 32'h77);
      checkOutput("simul.flags", flags_o, 32'h8);
      stepCycle("simul");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1, 31);
    end

    // Undriven address on a disabled port
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'x, 0, 'x);
    #2;
    checkOutput("xaddr.rdata1", rdata1, 32'h0);
    checkOutput("xaddr.rdata2", rdata2, 32'h0);
    stepCycle("xaddr");

    // Randomized traffic; address fields narrowed often to provoke bypass/collisions
    for (int c = 0; c < 400; c++) begin
      logic [4:0] wd;
      wd = 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 40) == 0),
                    1'($urandom), wd, $urandom,
                    1'($urandom), $urandom, $urandom,
                    1'($urandom), $urandom,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wd : 5'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wd : 5'($urandom));
      stepCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural state block at the write-back end of the 5-stage pipeline. Consumes the registered write-back bundle from the mem/wb pipeline register.
- Holds the 32x32 general register file, the HI/LO multiply result pair and the 32-bit flags register.
- Serves two combinational read ports for the decode stage, plus HI/LO/flags read-out for execute.
- Internal write-to-read bypass lets decode see a value committed in the same cycle without a stall.

Parameters:
- DATA_W, 32, width of GPRs, HI, LO and flags.
- ADDR_W, 5, GPR address width; depth is 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_wd  in  ADDR_W  GPR write address.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  DATA_W  GPR write data.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- wb_we  in  1  HI/LO write enable; writes both together.
- wb_flags  in  DATA_W  flags write data.
- wb_flags_we  in  1  flags write enable; low for bubbles.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.
- flags_o  out  DATA_W  current flags, bypassed.

Behaviour:
- Reset:
  - rst high at a rising edge clears all 32 GPRs, HI, LO and flags to 0.
  - Writes presented in that cycle are discarded; reset has priority.
  - While rst is high, all outputs (rdata1, rdata2, hi_o, lo_o, flags_o) are forced to 0 combinationally.
  - The first edge with rst low accepts writes normally.
- GPR write:
  - At a rising edge with wb_wreg=1 and wb_wd!=0, the register at wb_wd is loaded with wb_wdata.
  - wb_wd=0 is never written; r0 reads 0 always.
  - Write latency is 1 edge.
- Read port n (n=1,2), combinational, evaluated in this priority order:
  - rst=1 -> 0
  - else ren=0 -> 0
  - else raddrn=0 -> 0
  - else raddrn==wb_wd and wb_wreg=1 -> wb_wdata (bypass)
  - else stored register.
- Both ports may address the same register, including the one being written, in the same cycle; both return identical values.
- HI/LO:
  - At an edge with wb_we=1, HI<=wb_hi and LO<=wb_lo.
  - hi_o/lo_o return wb_hi/wb_lo when wb_we=1, otherwise the stored values.
- Flags:
  - At an edge with wb_flags_we=1, flags<=wb_flags.
  - flags_o returns wb_flags when wb_flags_we=1, otherwise the stored value.
- GPR, HI/LO and flags writes are independent; all three may occur in one cycle.
- No handshake and no stall output: every write is accepted every cycle.
- X on a disabled read address must not propagate; the output is still 0.

Test Plan:
- Reset: hold rst 2 cycles with wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF -> after release, re1=1, raddr1=5 reads 0; hi_o=lo_o=flags_o=0; outputs are 0 while rst is high.
- Write/read: write r7=0x12345678 in cycle N. Cycle N+1, no write, raddr1=7 -> 0x12345678. Cycle N, raddr2=7 -> 0x12345678 via bypass.
- r0: wb_wreg=1, wb_wd=0, wb_wdata=0xFFFFFFFF -> raddr1=0 reads 0 in the same cycle and the next; no other register changes.
- Read enables: r3=0xA5A5A5A5, re1=0, raddr1=3 -> rdata1=0. Same cycle, re2=1, raddr2=3 -> rdata2=0xA5A5A5A5.
- HI/LO/flags:
  - wb_we=1, hi=0x1, lo=0x2 -> hi_o=0x1, lo_o=0x2 in the same cycle and persisting.
  - Next cycle, wb_we=0 with hi=0x9 -> hi_o stays 0x1.
  - flags: wb_flags_we=0, wb_flags=0xF -> flags_o unchanged.
- Simultaneous: one cycle writes r31=0x55, HI/LO=0x66/0x77 and flags=0x8, with raddr1=raddr2=31 -> rdata1=rdata2=0x55, hi_o=0x66, lo_o=0x77, flags_o=0x8. All values persist afterwards.
